// File: rtl/crc_lfsr_param_pkg.sv
// Shared types and default constants for the parametrised CRC generator/checker.
package crc_pkg;

    // Controller states: waiting, absorbing message words, shifting CRC out.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int unsigned CRC_W_DEF = 8;
    localparam logic [7:0]  POLY_DEF  = 8'b0100_0100;
    localparam logic [7:0]  SEED_DEF  = 8'hD8;
    localparam int unsigned IN_W_DEF  = 1;

endpackage

// File: rtl/crc_lfsr_param_if.sv
// Message/CRC bus between the framer side and the CRC block.
interface crc_lfsr_param_if
    import crc_pkg::*;
#(
    parameter int unsigned IN_W = IN_W_DEF
) ();

    logic [IN_W-1:0] data;
    logic            active;
    logic            mode;
    logic            crc;
    logic            valid;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output data, active, mode,
        input  crc, valid, busy, done, err
    );

    modport slave (
        input  data, active, mode,
        output crc, valid, busy, done, err
    );

endinterface

// File: rtl/crc_lfsr_param_step.sv
// Combinational multi-bit update of a right-shifting Galois LFSR.
module crc_lfsr_step #(
    parameter int unsigned     CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY = 8'h44,
    parameter int unsigned     IN_W  = 1
) (
    input  logic [CRC_W-1:0] lfsr_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [CRC_W-1:0] lfsr_o
);

    logic [CRC_W-1:0] cur_s;
    logic [CRC_W-1:0] nxt_s;
    logic             fb_s;

    // Chain IN_W single-bit steps, data_i[0] entering the register first.
    always_comb begin
        cur_s = lfsr_i;
        nxt_s = lfsr_i;
        fb_s  = 1'b0;
        for (int k = 0; k < int'(IN_W); k++) begin
            fb_s             = data_i[k] ^ cur_s[0];
            nxt_s[CRC_W-1]   = fb_s;
            for (int i = 0; i < int'(CRC_W) - 1; i++) begin
                nxt_s[i] = cur_s[i+1] ^ (POLY[i] & fb_s);
            end
            cur_s = nxt_s;
        end
        lfsr_o = cur_s;
    end

endmodule

// File: rtl/crc_lfsr_param.sv
// CRC generator/checker: absorbs IN_W bits per active cycle, then either
// shifts the CRC out LSB first or reports a residue-based pass/fail flag.
module crc_lfsr_param
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W = CRC_W_DEF,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF),
    parameter logic [CRC_W-1:0] SEED  = CRC_W'(SEED_DEF),
    parameter int unsigned      IN_W  = IN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    crc_lfsr_param_if.slave  bus
);

    localparam int unsigned      CNT_W    = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    // Bit 0 leaves on the CALC->OUT edge, so the last OUT edge sees CRC_W-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 2);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    logic [CRC_W-1:0] step_s;
    logic [CRC_W-1:0] shift_s;
    logic [IN_W-1:0]  data_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             crc_q, crc_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    assign data_s  = bus.data;
    assign shift_s = {1'b0, lfsr_q[CRC_W-1:1]};

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .IN_W  (IN_W)
    ) u_step (
        .lfsr_i (lfsr_q),
        .data_i (data_s),
        .lfsr_o (step_s)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.active) begin
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (bus.active) begin
                    state_d = CALC;
                end else if (!mode_q) begin
                    state_d = OUT;
                end else begin
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values for the current state.
    always_comb begin
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        crc_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.active) begin
                    lfsr_d = step_s;
                    mode_d = bus.mode;
                    err_d  = 1'b0;
                end else begin
                    lfsr_d = SEED;
                end
            end
            CALC: begin
                if (bus.active) begin
                    lfsr_d = step_s;
                end else if (!mode_q) begin
                    // First CRC bit leaves on the same edge that ends the message.
                    crc_d   = lfsr_q[0];
                    valid_d = 1'b1;
                    lfsr_d  = shift_s;
                    cnt_d   = '0;
                end else begin
                    // Appended CRC drives a correct frame to a zero residue.
                    err_d  = |lfsr_q;
                    done_d = 1'b1;
                    lfsr_d = SEED;
                end
            end
            OUT: begin
                crc_d   = lfsr_q[0];
                valid_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    done_d = 1'b1;
                    lfsr_d = SEED;
                    cnt_d  = '0;
                end else begin
                    lfsr_d = shift_s;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                lfsr_d = SEED;
                cnt_d  = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            crc_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            crc_q   <= crc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.crc   = crc_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

endmodule

// File: doc/crc_lfsr_param.md
# crc_lfsr_param

Parametrised CRC generator and checker, built on a right-shifting Galois LFSR. It replaces the fixed 8-bit serial CRC block. It accepts an IN_W-bit data word on every cycle while ACTIVE is high. In generate mode it then shifts the CRC_W-bit result out serially. In check mode it reports a pass/fail flag against a received CRC that was appended to the message. It sits between the serial framer and the link transmitter/receiver.

## Interface
- CRC_W, 8: LFSR/CRC width; valid range 2..32.
- POLY, 8'b0100_0100: tap mask. Bit i set means an XOR tap at register bit i. Bit CRC_W-1 is ignored.
- SEED, 8'hD8: LFSR value loaded at reset and at the end of every message.
- IN_W, 1: data bits consumed per active cycle; valid range 1..CRC_W.
- CLK, input, 1: single clock, rising edge.
- RST, input, 1: reset. **Synchronous, active-low.**
- DATA, input, IN_W: message word. Bit 0 is processed first.
- ACTIVE, input, 1: message-valid strobe. A word is consumed on every edge where ACTIVE=1 and the state is IDLE or CALC.
- MODE, input, 1: 0 = generate, 1 = check. Sampled on the IDLE→CALC edge only.
- CRC, output, 1: serial CRC bit, LSB first.
- VALID, output, 1: high while CRC carries a CRC bit.
- BUSY, output, 1: high in CALC and OUT.
- DONE, output, 1: one-cycle completion pulse.
- ERR, output, 1: check result. 1 = mismatch. Held until the next message starts.

## Operation
- **Single-bit step (input bit b):**
  - fb = b ^ lfsr[0]
  - next[CRC_W-1] = fb
  - for i < CRC_W-1: next[i] = lfsr[i+1] ^ (POLY[i] & fb)
- **Per-word update:** IN_W steps are chained combinationally, DATA[0] first.
- **States:** IDLE, CALC, OUT.
- **IDLE:**
  - lfsr holds SEED.
  - If ACTIVE=1: consume DATA, latch MODE into mode_r, clear ERR, go to CALC.
- **CALC:**
  - If ACTIVE=1: consume DATA, stay in CALC.
  - If ACTIVE=0 and mode_r=0: go to OUT, bit counter = 0.
  - If ACTIVE=0 and mode_r=1: ERR = (lfsr != 0), DONE=1, lfsr = SEED, go to IDLE.
  - Check mode expects the transmitted CRC appended LSB first, so a correct frame leaves residue zero.
- **OUT:**
  - Each cycle: CRC = lfsr[0], VALID=1, lfsr shifts right with zero fill.
  - After CRC_W bits: lfsr = SEED, go to IDLE.
  - ACTIVE is ignored in OUT; data presented during OUT is dropped.
- **Edge cases:**
  - A message of one active cycle is legal.
  - If ACTIVE never rises, the block produces no output.
- **Counter:** $clog2(CRC_W) bits; wraps at CRC_W-1.

## Timing
- **Reset values:** state=IDLE, lfsr=SEED, CRC=0, VALID=0, BUSY=0, DONE=0, ERR=0, mode_r=0, counter=0.
- **Register boundary:** all outputs are registered; there are no combinational input-to-output paths.
- **Generate latency:** the edge that samples ACTIVE=0 in CALC also drives the first CRC bit with VALID=1.
  - VALID stays high for exactly CRC_W consecutive cycles.
  - DONE=1 coincides with the last CRC bit.
- **Check latency:** ERR and DONE update on the edge that samples ACTIVE=0 in CALC. DONE lasts one cycle.
- **Back-to-back messages:** earliest next message is ACTIVE=1 sampled on the edge after the last VALID cycle, i.e. in IDLE.
- **Reset mid-operation:** RST=0 sampled on any edge returns everything to reset values on that edge. A CRC shift in progress is truncated and DONE is not issued.
- **MODE:** changes outside the IDLE→CALC edge have no effect.

## Structure
- **Package crc_pkg:** state enum {IDLE, CALC, OUT}; default constants CRC_W_DEF, POLY_DEF, SEED_DEF.
- **Sub-module crc_lfsr_step:** purely combinational; parameters CRC_W, POLY, IN_W; inputs lfsr and data word; output next lfsr. The top level owns the FSM, counter and output registers.

## Test plan
- **Reset:** hold RST=0 for 2 edges mid-OUT → next cycle VALID=0, DONE=0, BUSY=0, ERR=0, lfsr=SEED.
- **Single-bit generate:** SEED=0 override, IN_W=1, one word DATA=1 → lfsr=8'hC4. Serial CRC, 8 cycles with VALID=1: 0,0,1,0,0,0,1,1. DONE on the 8th bit.
- **Default generate:** 1-byte message 1,0,0,0,1,1,1,0, then a 3-byte message back-to-back after IDLE → each CRC matches the bit-accurate golden model. VALID spans exactly 8 cycles each time. BUSY is low exactly one cycle between messages.
- **Check mode:** message plus its generated CRC appended LSB first → ERR=0, DONE pulse. The same frame with one payload bit flipped → ERR=1.
- **Width variants:** IN_W=4 and IN_W=8 with CRC_W=16, POLY=16'h8408, SEED=16'hFFFF → CRC equals the IN_W=1 run on the same bitstream. VALID spans 16 cycles.
- **ACTIVE during OUT:** assert ACTIVE with data during OUT → that data is ignored, the CRC is unchanged, and no new message starts until IDLE.
